// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared definitions for the calculator sequencer: state
//                encoding, ASCII constants and the output line length.
//  Revision    : 1.0  initial release
// ============================================================================
package calc_pkg;

    // Number of bytes in every output line: 4 payload characters, CR, LF
    localparam int c_LINE_LEN = 6;

    // ASCII characters used to build the output line
    localparam logic [7:0] c_ASCII_CR   = 8'h0D;
    localparam logic [7:0] c_ASCII_LF   = 8'h0A;
    localparam logic [7:0] c_ASCII_E    = 8'h45;
    localparam logic [7:0] c_ASCII_R    = 8'h52;
    localparam logic [7:0] c_ASCII_BANG = 8'h21;
    localparam logic [7:0] c_ASCII_T    = 8'h54;
    localparam logic [7:0] c_ASCII_O    = 8'h4F;
    localparam logic [7:0] c_ASCII_U    = 8'h55;

    // Sequencer state encoding
    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_ISSUE    = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ALU = 3'd2;
    localparam logic [2:0] c_ST_LOAD     = 3'd3;
    localparam logic [2:0] c_ST_WAIT_TX  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = c_ST_IDLE,
        ST_ISSUE    = c_ST_ISSUE,
        ST_WAIT_ALU = c_ST_WAIT_ALU,
        ST_LOAD     = c_ST_LOAD,
        ST_WAIT_TX  = c_ST_WAIT_TX
    } calc_state_t;

endpackage
`default_nettype wire

// File: rtl/calc_hex_ascii.sv
`default_nettype none
// ============================================================================
//  Module      : calc_hex_ascii
//  Description : Combinational conversion of one 4-bit nibble to its
//                uppercase ASCII hex digit ('0'-'9', 'A'-'F').
//  Revision    : 1.0  initial release
// ============================================================================
module calc_hex_ascii (
    input  logic [3:0] i_nibble,
    output logic [7:0] o_ascii
);

    // 0-9 map onto 0x30-0x39, 10-15 onto 0x41-0x46
    assign o_ascii = (i_nibble < 4'd10) ? {4'h3, i_nibble}
                                        : (8'h37 + {4'h0, i_nibble});

endmodule
`default_nettype wire

// File: rtl/calc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : calc_seq
//  Description : Sequencer between the command interpreter, the ALU and the
//                UART transmitter. Latches a command on rdy, launches the
//                ALU, then sends the result as a 6-byte ASCII line
//                (4 hex digits or "ERR!", then CR LF). Commands arriving
//                while busy are dropped and flagged on the sticky ovf.
//                Optional macro CALC_SEQ_TIMEOUT_EN adds an ALU timeout that
//                sends "TOUT" after TO_CYCLES cycles without alu_done.
//  Revision    : 1.0  initial release
// ============================================================================
module calc_seq
    import calc_pkg::*;
#(
    parameter int W_OP  = 8,
    parameter int W_RES = 16
`ifdef CALC_SEQ_TIMEOUT_EN
    ,
    parameter int TO_CYCLES = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic [W_OP-1:0]  op_A,
    input  logic [W_OP-1:0]  op_B,
    input  logic [3:0]       cmd,
    output logic [W_OP-1:0]  alu_a,
    output logic [W_OP-1:0]  alu_b,
    output logic [3:0]       alu_cmd,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [W_RES-1:0] alu_res,
    input  logic             alu_err,
    output logic [7:0]       tx_data,
    output logic             tx_strt,
    input  logic             tx_busy,
    output logic             busy,
    output logic             ovf
);

    localparam logic [2:0] c_LAST_IDX = 3'(c_LINE_LEN - 1);

    calc_state_t r_state;
    calc_state_t w_state_nxt;
    logic [2:0]  r_idx;
    logic [7:0]  r_line [0:c_LINE_LEN-1];
    logic        r_tx_first;     // first WAIT_TX cycle: tx_busy not yet up
    logic [7:0]  w_digit [0:3];
    logic        w_latch;
    logic        w_issue;
    logic        w_capture;
    logic        w_send;
    logic        w_advance;
    logic        w_timeout;

    // One converter per printed digit, most significant nibble first
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            calc_hex_ascii u_hex (
                .i_nibble (alu_res[W_RES-1-4*gi -: 4]),
                .o_ascii  (w_digit[gi])
            );
        end
    endgenerate

`ifdef CALC_SEQ_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TO_CYCLES + 1);
    logic [c_TO_W-1:0] r_to_cnt;

    // Cycles spent in WAIT_ALU; held at zero in every other state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_to_cnt <= '0;
        else if (r_state != ST_WAIT_ALU)
            r_to_cnt <= '0;
        else
            r_to_cnt <= r_to_cnt + 1'b1;
    end

    // Expiry on the last allowed cycle; a simultaneous alu_done takes priority
    assign w_timeout = (r_state == ST_WAIT_ALU) && !alu_done &&
                       (r_to_cnt == c_TO_W'(TO_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Next-state logic and one-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_issue     = 1'b0;
        w_capture   = 1'b0;
        w_send      = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rdy) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_issue     = 1'b1;
                w_state_nxt = ST_WAIT_ALU;
            end
            ST_WAIT_ALU: begin
                if (alu_done || w_timeout) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!tx_busy) begin
                    w_send      = 1'b1;
                    w_state_nxt = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (!r_tx_first && !tx_busy) begin
                    w_advance   = 1'b1;
                    w_state_nxt = (r_idx == c_LAST_IDX) ? ST_IDLE : ST_LOAD;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ALU interface: operands latched once per command, start pulse registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cmd   <= '0;
            alu_start <= 1'b0;
        end else begin
            alu_start <= w_issue;
            if (w_latch) begin
                alu_a   <= op_A;
                alu_b   <= op_B;
                alu_cmd <= cmd;
            end
        end
    end

    // Line buffer: result digits, "ERR!" or "TOUT", always terminated CR LF
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < c_LINE_LEN; i++)
                r_line[i] <= '0;
        end else if (w_capture) begin
            if (!alu_done) begin
                r_line[0] <= c_ASCII_T;
                r_line[1] <= c_ASCII_O;
                r_line[2] <= c_ASCII_U;
                r_line[3] <= c_ASCII_T;
            end else if (alu_err) begin
                r_line[0] <= c_ASCII_E;
                r_line[1] <= c_ASCII_R;
                r_line[2] <= c_ASCII_R;
                r_line[3] <= c_ASCII_BANG;
            end else begin
                for (int i = 0; i < 4; i++)
                    r_line[i] <= w_digit[i];
            end
            r_line[4] <= c_ASCII_CR;
            r_line[5] <= c_ASCII_LF;
        end
    end

    // TX interface, byte index and the sticky drop flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_data    <= '0;
            tx_strt    <= 1'b0;
            r_tx_first <= 1'b0;
            r_idx      <= '0;
            ovf        <= 1'b0;
        end else begin
            tx_strt    <= w_send;
            r_tx_first <= w_send;
            if (r_state == ST_LOAD)
                tx_data <= r_line[r_idx];
            if (w_advance)
                r_idx <= (r_idx == c_LAST_IDX) ? 3'd0 : r_idx + 3'd1;
            if (rdy && (r_state != ST_IDLE))
                ovf <= 1'b1;
        end
    end

    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_calc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_seq
//  Description : Directed self-checking bench for calc_seq with a simple
//                UART TX responder that records every transmitted byte.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_calc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b0;
    logic [7:0]  op_A = '0;
    logic [7:0]  op_B = '0;
    logic [3:0]  cmd = '0;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_cmd;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic [15:0] alu_res = '0;
    logic        alu_err = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_strt;
    logic        tx_busy;
    logic        busy;
    logic        ovf;

    logic        r_hold = 1'b0;
    int          r_tx_cnt = 0;
    int          n_strt = 0;
    logic [7:0]  q_tx[$];

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    calc_seq #(
        .W_OP  (8),
        .W_RES (16)
`ifdef CALC_SEQ_TIMEOUT_EN
        ,
        .TO_CYCLES (8)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .op_A      (op_A),
        .op_B      (op_B),
        .cmd       (cmd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cmd   (alu_cmd),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .alu_res   (alu_res),
        .alu_err   (alu_err),
        .tx_data   (tx_data),
        .tx_strt   (tx_strt),
        .tx_busy   (tx_busy),
        .busy      (busy),
        .ovf       (ovf)
    );

    // UART responder: busy for 4 cycles starting the cycle after tx_strt
    assign tx_busy = (r_tx_cnt != 0) || r_hold;

    always @(posedge clk) begin
        if (tx_strt) begin
            q_tx.push_back(tx_data);
            n_strt   <= n_strt + 1;
            r_tx_cnt <= 4;
        end else if (r_tx_cnt != 0) begin
            r_tx_cnt <= r_tx_cnt - 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] c);
        rdy  = 1'b1;
        op_A = a;
        op_B = b;
        cmd  = c;
        @(negedge clk);
        rdy  = 1'b0;
        op_A = 8'hxx;
        op_B = 8'hxx;
    endtask

    task automatic wait_start(input string tag);
        for (int i = 0; i < 20 && !alu_start; i++) @(negedge clk);
        check_val(tag, {31'd0, alu_start}, 32'd1);
    endtask

    task automatic alu_reply(input logic [15:0] res, input logic err);
        alu_done = 1'b1;
        alu_res  = res;
        alu_err  = err;
        @(negedge clk);
        alu_done = 1'b0;
        alu_err  = 1'b0;
    endtask

    task automatic expect_line(input string tag, input logic [47:0] exp);
        logic [7:0] b;
        for (int i = 0; i < 1000 && busy; i++) @(negedge clk);
        check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check_val({tag, "_cnt"}, q_tx.size(), 32'd6);
        for (int k = 0; k < 6; k++) begin
            b = (q_tx.size() > k) ? q_tx[k] : 8'hFF;
            check_val($sformatf("%s_b%0d", tag, k), {24'd0, b},
                      {24'd0, exp[47-8*k -: 8]});
        end
        q_tx.delete();
    endtask

    initial begin
        int s0;
        repeat (3) @(negedge clk);
        // Reset values while rst is held
        check_val("rst_alu_a", {24'd0, alu_a}, 32'h0);
        check_val("rst_alu_cmd", {28'd0, alu_cmd}, 32'h0);
        check_val("rst_start", {31'd0, alu_start}, 32'h0);
        check_val("rst_tx_data", {24'd0, tx_data}, 32'h0);
        check_val("rst_tx_strt", {31'd0, tx_strt}, 32'h0);
        check_val("rst_busy", {31'd0, busy}, 32'h0);
        check_val("rst_ovf", {31'd0, ovf}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Normal result with exact latencies
        send_cmd(8'h02, 8'h15, 4'h1);
        check_val("t1_start_early", {31'd0, alu_start}, 32'd0);
        check_val("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check_val("t1_start_2cyc", {31'd0, alu_start}, 32'd1);
        check_val("t1_alu_a", {24'd0, alu_a}, 32'h02);
        check_val("t1_alu_b", {24'd0, alu_b}, 32'h15);
        check_val("t1_alu_cmd", {28'd0, alu_cmd}, 32'h1);
        alu_reply(16'h0017, 1'b0);
        check_val("t1_strt_early", {31'd0, tx_strt}, 32'd0);
        @(negedge clk);
        check_val("t1_strt_2cyc", {31'd0, tx_strt}, 32'd1);
        check_val("t1_data0", {24'd0, tx_data}, 32'h30);
        expect_line("t1", 48'h3030_3137_0D0A);
        check_val("t1_ovf", {31'd0, ovf}, 32'd0);

        // Hex letters
        send_cmd(8'h10, 8'h20, 4'h2);
        wait_start("t2_start");
        alu_reply(16'hBEEF, 1'b0);
        expect_line("t2", 48'h4245_4546_0D0A);

        // ALU error
        send_cmd(8'h05, 8'h00, 4'h3);
        wait_start("t3_start");
        alu_reply(16'h1234, 1'b1);
        expect_line("t3", 48'h4552_5221_0D0A);

        // Overlapping command during WAIT_TX is dropped
        send_cmd(8'h02, 8'h15, 4'h1);
        wait_start("t4_start");
        alu_reply(16'h0017, 1'b0);
        for (int i = 0; i < 20 && !tx_strt; i++) @(negedge clk);
        send_cmd(8'h99, 8'h77, 4'hF);
        check_val("t4_ovf", {31'd0, ovf}, 32'd1);
        check_val("t4_alu_a", {24'd0, alu_a}, 32'h02);
        check_val("t4_alu_cmd", {28'd0, alu_cmd}, 32'h1);
        expect_line("t4", 48'h3030_3137_0D0A);

        // TX backpressure before the first byte
        r_hold = 1'b1;
        send_cmd(8'h01, 8'h01, 4'h1);
        wait_start("t5_start");
        alu_reply(16'h9A0C, 1'b0);
        s0 = n_strt;
        repeat (50) @(negedge clk);
        check_val("t5_no_strt", n_strt - s0, 32'd0);
        check_val("t5_busy", {31'd0, busy}, 32'd1);
        r_hold = 1'b0;
        expect_line("t5", 48'h3941_3043_0D0A);

        // Reset after the third byte abandons the line
        send_cmd(8'h12, 8'h34, 4'h4);
        wait_start("t6_start");
        alu_reply(16'h1234, 1'b0);
        for (int i = 0; i < 200 && q_tx.size() < 3; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_val("t6_rst_ovf", {31'd0, ovf}, 32'd0);
        check_val("t6_rst_alu_a", {24'd0, alu_a}, 32'h0);
        check_val("t6_rst_tx_data", {24'd0, tx_data}, 32'h0);
        check_val("t6_rst_tx_strt", {31'd0, tx_strt}, 32'd0);
        s0 = n_strt;
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check_val("t6_no_more", n_strt - s0, 32'd0);
        check_val("t6_cnt", q_tx.size(), 32'd3);
        check_val("t6_b2", {24'd0, (q_tx.size() > 2) ? q_tx[2] : 8'hFF}, 32'h33);
        q_tx.delete();

        // alu_done outside WAIT_ALU is ignored
        alu_reply(16'h5555, 1'b0);
        check_val("t7_idle_done", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        check_val("t7_no_strt", q_tx.size(), 32'd0);

`ifdef CALC_SEQ_TIMEOUT_EN
        // Withheld alu_done: timeout line after TO_CYCLES cycles
        send_cmd(8'h03, 8'h04, 4'h5);
        wait_start("t8_start");
        expect_line("t8", 48'h544F_5554_0D0A);
`else
        // Without the timeout the sequencer waits indefinitely
        send_cmd(8'h03, 8'h04, 4'h5);
        wait_start("t8_start");
        repeat (300) @(negedge clk);
        check_val("t8_waiting", {31'd0, busy}, 32'd1);
        check_val("t8_no_strt", q_tx.size(), 32'd0);
        alu_reply(16'h0A5C, 1'b0);
        expect_line("t8", 48'h3041_3543_0D0A);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
